mac_result_packer: RTL and testbench
====================================

MAC_RESULT_PACKER -- requirements
Module: mac_result_packer

Interface
REQ-001: clk  input  1  -- single clock; all state updates on rising edge.
REQ-002: rst  input  1  -- synchronous, active-high reset.
REQ-003: in_valid  input  1  -- signed_sum/exp_max valid this cycle.
REQ-004: in_ready  output  1  -- packer can accept a result; a transfer occurs when in_valid and in_ready are both high.
REQ-005: signed_sum  input  20  -- two's-complement adder-tree sum.
REQ-006: exp_max  input  5  -- max exponent associated with signed_sum.
REQ-007: out_valid  output  1  -- out_data holds a packed result.
REQ-008: out_ready  input  1  -- consumer accepts out_data when high together with out_valid.
REQ-009: out_data  output  16  -- {sign, exp[4:0], man[9:0]} half-precision word.
REQ-010: result_cnt  output  16  -- count of completed output transfers; wraps at 65535 -> 0.

Function
REQ-011: Packing SHALL use a two-stage pipeline (S1: sign, magnitude, leading-one position; S2: exponent/mantissa pack) feeding a 4-entry FIFO.
REQ-012: sign = signed_sum[19]; magnitude = |signed_sum| as 20-bit unsigned (-2^19 -> 2^19).
REQ-013: p = index of the most significant 1 in magnitude (0..19).
REQ-014: E = exp_max + p - 8, computed in 7-bit signed (range -8..42).
REQ-015: Mantissa = the 10 bits directly below the leading one, truncated toward zero; when p<10, missing low bits are zero-filled.
REQ-016: magnitude==0 SHALL pack to {sign=0, 15'b0} = 16'h0000.
REQ-017: E>=31 SHALL saturate to {sign, 5'd30, 10'h3FF}.
REQ-018: 1<=E<=30 SHALL pack to {sign, E[4:0], mantissa}.
REQ-019: E<=0 is handled per REQ-030/REQ-031.
REQ-020: Latency: a result accepted in cycle N is written to the FIFO at the end of cycle N+2, so out_valid is high in cycle N+3 if the FIFO was empty.
REQ-021: Occupancy = FIFO count + valid S1 + valid S2; in_ready = (occupancy < 4), computed from registered state only; a same-cycle pop does not raise in_ready until the next cycle.
REQ-022: Results SHALL leave in acceptance order; out_data SHALL stay stable while out_valid is high and out_ready is low.
REQ-023: A simultaneous FIFO write and pop SHALL leave the count unchanged; the pointers SHALL wrap modulo 4.
REQ-024: The FIFO SHALL never overflow or underflow; out_valid = (count != 0).
REQ-025: result_cnt SHALL increment by 1 on every out_valid and out_ready cycle.

Reset
REQ-026: On rst high at a clock edge, S1/S2 valid bits, FIFO pointers, count and result_cnt SHALL clear to 0.
REQ-027: Outputs during and after reset: in_ready=1, out_valid=0, out_data=16'h0000, result_cnt=0.
REQ-028: Reset mid-operation SHALL discard all in-flight and buffered results; no partial output SHALL appear afterwards.

Configuration
REQ-029: Macro SUBNORMAL_EN selects E<=0 handling.
REQ-030: With SUBNORMAL_EN defined: s = 1-E; out = {sign, 5'd0, ({1'b1, mantissa} >> s)[9:0]}; when s>10, the mantissa field is 0.
REQ-031: Without SUBNORMAL_EN: E<=0 flushes to {sign, 15'b0}.

Verification
REQ-032: signed_sum=20'h00400, exp_max=15, out_ready=1 -> out_data=16'h4400, out_valid exactly 3 cycles after acceptance, result_cnt=1.
REQ-033: signed_sum=20'hFFC00, exp_max=15 -> 16'hC400; signed_sum=0, exp_max=20 -> 16'h0000.
REQ-034: signed_sum=20'h40000, exp_max=31 -> saturated 16'h7BFF.
REQ-035: signed_sum=20'h00001, exp_max=8 -> 16'h0200 with SUBNORMAL_EN, 16'h0000 without.
REQ-036: Backpressure: out_ready=0, in_valid held high with 4 distinct sums -> in_ready low after the 4th accept; out_data stable; raise out_ready for 1 cycle -> first result pops and in_ready returns high the next cycle; all 4 results emerge in order.
REQ-037: Assert rst while 2 results are buffered and 1 is in S1 -> next cycle out_valid=0, in_ready=1, result_cnt=0, and no stale output appears afterwards.

Source files
------------

// File: rtl/mac_result_packer.sv
// ============================================================================
// Module   : mac_result_packer
// Brief    : Packs 20-bit adder-tree sums plus a max exponent into half-precision
//            words through a 2-stage pipeline and a 4-entry output FIFO.
//            Optional macro SUBNORMAL_EN produces subnormals for E<=0
//            (default build flushes them to signed zero).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_result_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] signed_sum,
    input  logic [4:0]  exp_max,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [15:0] result_cnt
);

    localparam int unsigned C_DEPTH = 4;

    // Stage 1 registers
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [19:0] r_s1_mag;
    logic [4:0]  r_s1_p;
    logic [4:0]  r_s1_exp;

    // Stage 2 registers
    logic        r_s2_valid;
    logic [15:0] r_s2_data;

    // FIFO
    logic [15:0] r_mem [C_DEPTH];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [15:0] r_result_cnt;

    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_occ;
    logic [19:0] w_mag;
    logic [4:0]  w_p;
    logic signed [6:0] w_e;
    logic [9:0]  w_mant;
    logic [15:0] w_pack;

    // The pipeline never stalls: admission control keeps total occupancy <= 4,
    // so the FIFO always has room for whatever leaves S2.
    assign w_occ     = r_count + {2'b00, r_s1_valid} + {2'b00, r_s2_valid};
    assign in_ready  = (w_occ < 3'd4);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = r_s2_valid;
    assign out_valid = (r_count != 3'd0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 16'h0000;
    assign result_cnt = r_result_cnt;

    assign w_mag = signed_sum[19] ? (~signed_sum + 20'd1) : signed_sum;

    always_comb begin
        w_p = 5'd0;
        for (int i = 0; i < 20; i++) begin
            if (w_mag[i]) begin
                w_p = 5'(i);
            end
        end
    end

    assign w_e    = $signed({2'b00, r_s1_exp}) + $signed({2'b00, r_s1_p}) - 7'sd8;
    // Normalise so the leading one sits at bit 19; mantissa is bits 18:9.
    assign w_mant = 10'((r_s1_mag << (5'd19 - r_s1_p)) >> 9);

`ifdef SUBNORMAL_EN
    logic [6:0] w_shift;
    logic [9:0] w_sub;
    assign w_shift = 7'd1 - w_e;
    assign w_sub   = (w_shift > 7'd10) ? 10'd0 : 10'({1'b1, w_mant} >> w_shift[3:0]);
`endif

    always_comb begin
        w_pack = 16'h0000;
        if (r_s1_mag == 20'd0) begin
            w_pack = 16'h0000;
        end else if (w_e > 7'sd30) begin
            w_pack = {r_s1_sign, 5'd30, 10'h3FF};
        end else if (w_e > 7'sd0) begin
            w_pack = {r_s1_sign, w_e[4:0], w_mant};
        end else begin
`ifdef SUBNORMAL_EN
            w_pack = {r_s1_sign, 5'd0, w_sub};
`else
            w_pack = {r_s1_sign, 15'd0};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_mag     <= 20'd0;
            r_s1_p       <= 5'd0;
            r_s1_exp     <= 5'd0;
            r_s2_valid   <= 1'b0;
            r_s2_data    <= 16'h0000;
            r_wr_ptr     <= 2'd0;
            r_rd_ptr     <= 2'd0;
            r_count      <= 3'd0;
            r_result_cnt <= 16'd0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sign <= signed_sum[19];
                r_s1_mag  <= w_mag;
                r_s1_p    <= w_p;
                r_s1_exp  <= exp_max;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_pack;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 2'd1;
                r_result_cnt <= r_result_cnt + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s2_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_result_packer.sv
// ============================================================================
// Module   : tb_mac_result_packer
// Brief    : Directed self-checking bench for mac_result_packer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_result_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] signed_sum;
    logic [4:0]  exp_max;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] result_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_cnt;

    localparam int C_NVEC = 9;
    logic [19:0] v_sum [C_NVEC];
    logic [4:0]  v_exp [C_NVEC];
    logic [15:0] v_out [C_NVEC];

    always #5 clk = ~clk;

    mac_result_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .signed_sum (signed_sum),
        .exp_max    (exp_max),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .result_cnt (result_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_one(input int i);
        int lat;
        @(negedge clk);
        check($sformatf("idle_ready_%0d", i), 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        signed_sum = v_sum[i];
        exp_max    = v_exp[i];
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("latency_%0d", i), 32'(lat), 32'd3);
        check($sformatf("data_%0d", i), 32'(out_data), 32'(v_out[i]));
        @(negedge clk);
        exp_cnt++;
        check($sformatf("result_cnt_%0d", i), 32'(result_cnt), 32'(exp_cnt));
    endtask

    initial begin
        v_sum[0] = 20'h00400; v_exp[0] = 5'd15; v_out[0] = 16'h4400;
        v_sum[1] = 20'hFFC00; v_exp[1] = 5'd15; v_out[1] = 16'hC400;
        v_sum[2] = 20'h00000; v_exp[2] = 5'd20; v_out[2] = 16'h0000;
        v_sum[3] = 20'h40000; v_exp[3] = 5'd31; v_out[3] = 16'h7BFF;
        v_sum[4] = 20'h00001; v_exp[4] = 5'd8;
        v_sum[5] = 20'h00555; v_exp[5] = 5'd10; v_out[5] = 16'h3155;
        v_sum[6] = 20'h7FFFF; v_exp[6] = 5'd0;  v_out[6] = 16'h2BFF;
        v_sum[7] = 20'h80000; v_exp[7] = 5'd0;  v_out[7] = 16'hAC00;
        v_sum[8] = 20'h00003; v_exp[8] = 5'd5;
`ifdef SUBNORMAL_EN
        v_out[4] = 16'h0200;
        v_out[8] = 16'h00C0;
`else
        v_out[4] = 16'h0000;
        v_out[8] = 16'h0000;
`endif

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        signed_sum = 20'd0;
        exp_max    = 5'd0;
        exp_cnt    = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_result_cnt", 32'(result_cnt), 32'd0);

        // Single transfers: packing and latency
        out_ready = 1'b1;
        for (int i = 0; i < C_NVEC; i++) begin
            run_one(i);
        end

        // Back-to-back stream with concurrent push and pop
        fork
            begin
                for (int i = 0; i < C_NVEC; i++) begin
                    int g;
                    @(negedge clk);
                    in_valid   = 1'b1;
                    signed_sum = v_sum[i];
                    exp_max    = v_exp[i];
                    g = 0;
                    while (!in_ready && g < 50) begin
                        @(negedge clk);
                        g++;
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int k;
                k = 0;
                for (int c = 0; c < 100 && k < C_NVEC; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check($sformatf("stream_%0d", k), 32'(out_data), 32'(v_out[k]));
                        k++;
                        exp_cnt++;
                    end
                end
                check("stream_count", 32'(k), 32'(C_NVEC));
            end
        join
        @(negedge clk);
        check("stream_result_cnt", 32'(result_cnt), 32'(exp_cnt));

        // Backpressure: fill all four slots
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd1);
            in_valid   = 1'b1;
            signed_sum = v_sum[i == 2 ? 5 : (i == 3 ? 6 : i)];
            exp_max    = v_exp[i == 2 ? 5 : (i == 3 ? 6 : i)];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'(v_out[0]));
        repeat (2) @(negedge clk);
        check("bp_head_stable", 32'(out_data), 32'(v_out[0]));
        check("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        check("bp_pop_cycle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt++;
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        check("bp_cnt_after_pop", 32'(result_cnt), 32'(exp_cnt));
        check("bp_second", 32'(out_data), 32'(v_out[1]));
        out_ready = 1'b1;
        check("bp_order_1", 32'(out_data), 32'(v_out[1]));
        @(negedge clk);
        check("bp_order_2", 32'(out_data), 32'(v_out[5]));
        @(negedge clk);
        check("bp_order_3", 32'(out_data), 32'(v_out[6]));
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd3;
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_final_cnt", 32'(result_cnt), 32'(exp_cnt));

        // Reset with two buffered results and one in S1
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; signed_sum = v_sum[0]; exp_max = v_exp[0];
        @(negedge clk);
        signed_sum = v_sum[1]; exp_max = v_exp[1];
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; signed_sum = v_sum[5]; exp_max = v_exp[5];
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result_cnt", 32'(result_cnt), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("post_rst_no_stale", 32'(seen), 32'd0);
        end
        check("post_rst_result_cnt", 32'(result_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
